// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: A+B+CI computed LSB first through one full adder, one bit per clock.
// Optional subtract mode (adds port sub, computes A-B) is enabled by defining SERIAL_ADDER_SUB_EN.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic         co
);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-1:0]   res_sr;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           sum_c;
  logic           cout_c;
  logic [N-1:0]   b_load_c;
  logic           c_load_c;

  // Subtraction is A + ~B + 1, so only the B and carry load values differ.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load_c = sub ? ~b : b;
  assign c_load_c = sub ? 1'b1 : ci;
`else
  assign b_load_c = b;
  assign c_load_c = ci;
`endif

  serial_adder_fa u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (sum_c),
    .cout (cout_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= '0;
      co     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load_c;
            carry <= c_load_c;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter from the MSB side so bit 0 lands at index 0 after N shifts.
          res_sr <= {sum_c, res_sr[N-1:1]};
          carry  <= cout_c;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            busy  <= 1'b0;
            state <= FIN;
          end
        end
        FIN: begin
          y     <= res_sr;
          co    <= carry;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (N=8): stimulus pushes expected results, a negedge monitor
// pops and checks them on every DONE. Define SERIAL_ADDER_SUB_EN to also cover subtract mode.

module tb_serial_adder_ctrl;
  localparam int unsigned N = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         ci    = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub   = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] y;
  logic         co;

  typedef struct {
    logic [N-1:0] y;
    logic         co;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         got;
  int           cyc      = 0;
  int           checks   = 0;
  int           errors   = 0;
  int           busy_cnt = 0;
  logic [N-1:0] last_y   = '0;
  logic         last_co  = 1'b0;

  serial_adder_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .y     (y),
    .co    (co)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset values, held outputs between completions, and each result with its latency.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_y", 32'(y), 32'(0));
      chk("rst_co", 32'(co), 32'(0));
      last_y   = '0;
      last_co  = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          got = sb.pop_front();
          chk("y", 32'(y), 32'(got.y));
          chk("co", 32'(co), 32'(got.co));
          chk("done_cycle", 32'(cyc), 32'(got.cyc));
          chk("busy_cycles", 32'(busy_cnt), 32'(N));
          last_y  = got.y;
          last_co = got.co;
        end
        busy_cnt = 0;
      end else begin
        chk("y_hold", 32'(y), 32'(last_y));
        chk("co_hold", 32'(co), 32'(last_co));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tci,
                        input logic [N-1:0] ey, input logic eco);
    exp_t e;
    wait_idle();
    a     = ta;
    b     = tb_v;
    ci    = tci;
    start = 1'b1;
    e.y   = ey;
    e.co  = eco;
    e.cyc = cyc + N + 2;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic launch_sub(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                            input logic [N-1:0] ey, input logic eco);
    wait_idle();
    sub = 1'b1;
    launch(ta, tb_v, 1'b1, ey, eco);
    sub = 1'b0;
  endtask
`endif

  initial begin
    exp_t e;
    int   c0;

    // START held during reset must not be accepted; the first edge after release takes it.
    a     = 8'h5A;
    b     = 8'h3C;
    ci    = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    e.y   = 8'h96;
    e.co  = 1'b0;
    e.cyc = cyc + N + 2;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;

    launch(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    launch(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    launch(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    launch(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    launch(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);

    // START held high: one result every N+2 cycles, operand noise during RUN ignored.
    wait_idle();
    a     = 8'h01;
    b     = 8'h01;
    ci    = 1'b0;
    start = 1'b1;
    c0    = cyc;
    for (int i = 0; i < 3; i++) begin
      e.y   = 8'h02;
      e.co  = 1'b0;
      e.cyc = c0 + N + 2 + i * (N + 2);
      sb.push_back(e);
    end
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy) begin
        a  = 8'hA5 ^ 8'(i);
        b  = 8'h3C + 8'(i);
        ci = 1'b1;
      end else begin
        a  = 8'h01;
        b  = 8'h01;
        ci = 1'b0;
      end
    end
    start = 1'b0;
    a     = 8'h01;
    b     = 8'h01;
    ci    = 1'b0;

    // Reset during the 4th RUN cycle aborts with no DONE and clears the held result.
    wait_idle();
    a     = 8'h5A;
    b     = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_y", 32'(y), 32'(0));
    chk("abort_co", 32'(co), 32'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    launch(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    launch_sub(8'h10, 8'h01, 8'h0F, 1'b1);
    launch_sub(8'h01, 8'h02, 8'hFF, 1'b0);
    launch(8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

    wait_idle();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
